cic_comb_decim: RTL and testbench

- Rate-change and first comb (differentiator) stage of the CIC decimator.
- Sits directly downstream of the integrator stage and consumes its registered, wrap-around integrator output at the oversampled rate.
- Selects one sample every R = 2^os_sel input clocks and emits y = x[k] − x[k−1] (modulo 2^DW) with a one-cycle valid strobe for the next comb stage or the output interface.

---
 rtl/cic_comb_decim.sv | 88 ++++++++
 tb/tb_cic_comb_decim.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cic_comb_decim.sv
// CIC decimator rate-change and first comb stage.
// Consumes the wrap-around integrator output at the oversampled rate, keeps one
// sample every R = 2^os_sel clocks and emits the first difference of the kept
// samples (modulo 2^DW) together with a one-cycle valid strobe.
module cic_comb_decim #(
  parameter int DW = 23,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [2:0]    os_sel,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic          out_valid,
  output logic          primed
);

  // Registered copy of os_sel; the ratio is always decoded from this copy so a
  // change is seen one cycle late and can be handled as a restart.
  logic [2:0]    os_sel_r;
  logic [CW-1:0] cnt_r;
  logic [DW-1:0] comb_r;

  logic [CW-1:0] ratio_m1_s;
  logic          chg_s;
  logic          tick_s;

  // Decode R-1 from the registered oversampling select; 0 and 7 mean R = 1.
  always_comb begin
    ratio_m1_s = '0;
    case (os_sel_r)
      3'd1:    ratio_m1_s = CW'(6'd1);
      3'd2:    ratio_m1_s = CW'(6'd3);
      3'd3:    ratio_m1_s = CW'(6'd7);
      3'd4:    ratio_m1_s = CW'(6'd15);
      3'd5:    ratio_m1_s = CW'(6'd31);
      3'd6:    ratio_m1_s = CW'(6'd63);
      default: ratio_m1_s = '0;
    endcase
  end

  // A select change suppresses the tick so no sample is taken with a stale ratio.
  always_comb begin
    chg_s  = (os_sel != os_sel_r);
    tick_s = 1'b0;
    if (chg_s) begin
      tick_s = 1'b0;
    end else begin
      tick_s = (cnt_r == ratio_m1_s);
    end
  end

  // Decimation counter, comb delay register and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      os_sel_r  <= 3'd0;
      cnt_r     <= '0;
      comb_r    <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      primed    <= 1'b0;
    end else begin
      os_sel_r <= os_sel;
      if (chg_s) begin
        // Restart priming with the new ratio; held data is left untouched.
        cnt_r     <= '0;
        primed    <= 1'b0;
        out_valid <= 1'b0;
      end else if (tick_s) begin
        cnt_r  <= '0;
        comb_r <= data_in;
        if (primed) begin
          // Modular difference: integrator wrap-around cancels here.
          data_out  <= data_in - comb_r;
          out_valid <= 1'b1;
        end else begin
          // First kept sample only loads the delay register.
          primed    <= 1'b1;
          out_valid <= 1'b0;
        end
      end else begin
        cnt_r     <= cnt_r + CW'(1'b1);
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cic_comb_decim.sv
// Self-checking bench for cic_comb_decim: a sample-queue reference model
// checked every cycle, plus directed scenarios with hand-computed results.
module tb_cic_comb_decim;

  localparam int DW = 23;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    os_sel = 3'd0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          out_valid;
  logic          primed;

  int n_chk  = 0;
  int n_fail = 0;

  cic_comb_decim #(.DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .os_sel    (os_sel),
    .data_in   (data_in),
    .data_out  (data_out),
    .out_valid (out_valid),
    .primed    (primed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ratio(input logic [2:0] s);
    return (s >= 3'd1 && s <= 3'd6) ? (1 << s) : 1;
  endfunction

  // Reference model: counts clocks since the last restart, keeps every R-th
  // input sample and outputs the difference of the two most recent samples.
  logic [2:0]    m_sel = 3'd0;
  int            m_since = 0;
  logic [DW-1:0] m_samp[$];
  logic [DW-1:0] m_data = '0;
  logic          m_valid = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_sel   = 3'd0;
      m_since = 0;
      m_samp.delete();
      m_data  = '0;
      m_valid = 1'b0;
    end else if (os_sel != m_sel) begin
      m_sel   = os_sel;
      m_since = 0;
      m_samp.delete();
      m_valid = 1'b0;
    end else begin
      m_since++;
      m_valid = 1'b0;
      if (m_since % ratio(m_sel) == 0) begin
        m_samp.push_back(data_in);
        if (m_samp.size() > 2) void'(m_samp.pop_front());
        if (m_samp.size() == 2) begin
          m_data  = m_samp[1] - m_samp[0];
          m_valid = 1'b1;
        end
      end
    end
    #1;
    chk("model_valid",  32'(out_valid), 32'(m_valid));
    chk("model_data",   32'(data_out),  32'(m_data));
    chk("model_primed", 32'(primed),    32'(m_samp.size() != 0));
  end

  // Drive new inputs at the falling edge; outputs then reflect the edge that
  // consumed the previously driven inputs.
  task automatic step(input logic [2:0] os, input logic [DW-1:0] din);
    @(negedge clk);
    os_sel  = os;
    data_in = din;
  endtask

  task automatic pass_thru(input logic [2:0] os);
    step(os, DW'(100));                  // select change cycle
    step(os, DW'(100));                  // priming sample
    chk("pt_primed_before", 32'(primed), 32'd0);
    step(os, DW'(103));
    chk("pt_prime_novalid", 32'(out_valid), 32'd0);
    chk("pt_primed", 32'(primed), 32'd1);
    step(os, DW'(110));
    chk("pt_valid1", 32'(out_valid), 32'd1);
    chk("pt_data1", 32'(data_out), 32'd3);
    step(os, DW'(110));
    chk("pt_valid2", 32'(out_valid), 32'd1);
    chk("pt_data2", 32'(data_out), 32'd7);
  endtask

  initial begin
    int nv;
    int last;
    int first_v;
    int second_v;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_primed", 32'(primed), 32'd0);
    reset_n = 1'b1;

    // Ramp at R = 4: every output equals 4 * 5 = 20.
    nv = 0;
    last = -1;
    for (int i = 0; i <= 44; i++) begin
      step(3'd2, DW'(5 * i));
      if (i >= 1) begin
        if (i == 4) chk("ramp_unprimed", 32'(primed), 32'd0);
        if (i == 5) begin
          chk("ramp_primed", 32'(primed), 32'd1);
          chk("ramp_prime_novalid", 32'(out_valid), 32'd0);
        end
        if (out_valid) begin
          chk("ramp_data", 32'(data_out), 32'd20);
          if (last >= 0) chk("ramp_gap", 32'(i - 1 - last), 32'd4);
          last = i - 1;
          nv++;
        end
      end
    end
    chk("ramp_count", 32'(nv), 32'd9);

    // Pass-through for both R = 1 encodings.
    pass_thru(3'd0);
    pass_thru(3'd7);

    // Wrap-around at R = 2: 0x000002 - 0x7FFFFE = 0x000004.
    step(3'd1, DW'(0));
    step(3'd1, DW'(5));
    step(3'd1, DW'(23'h7FFFFE));
    step(3'd1, DW'(9));
    step(3'd1, DW'(2));
    step(3'd1, DW'(2));
    chk("wrap_valid", 32'(out_valid), 32'd1);
    chk("wrap_data", 32'(data_out), 32'h000004);

    // Asynchronous reset mid-stream.
    step(3'd1, DW'(20'h12345));
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_data", 32'(data_out), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_primed", 32'(primed), 32'd0);
    step(3'd1, DW'(20'h12345));
    step(3'd1, DW'(20'h12345));
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(3'd1, DW'(20'h12345));
      chk("arst_no_valid", 32'(out_valid), 32'd0);
    end

    // Rate change on a tick cycle: R = 8 to R = 64 at edge 24.
    first_v = -1;
    second_v = -1;
    for (int k = 0; k <= 230; k++) begin
      step((k < 24) ? 3'd3 : 3'd6, DW'($urandom()));
      if (k >= 1) begin
        if (k - 1 == 24) begin
          chk("chg_no_valid", 32'(out_valid), 32'd0);
          chk("chg_primed_drop", 32'(primed), 32'd0);
        end
        if (k - 1 > 24 && out_valid) begin
          if (first_v < 0) first_v = k - 1;
          else if (second_v < 0) second_v = k - 1;
        end
      end
    end
    chk("chg_first_valid", 32'(first_v), 32'd152);
    chk("chg_second_valid", 32'(second_v), 32'd216);

    // Max ratio, constant input: every steady-state output is zero.
    nv = 0;
    last = -1;
    for (int k = 0; k < 400; k++) begin
      step(3'd6, DW'(12'hABC));
      if (k >= 150 && out_valid) begin
        chk("max_data", 32'(data_out), 32'd0);
        if (last >= 0) chk("max_gap", 32'(k - last), 32'd64);
        last = k;
        nv++;
      end
    end
    chk("max_count", 32'(nv >= 3), 32'd1);

    // Randomised run with occasional select changes and resets.
    for (int k = 0; k < 5000; k++) begin
      logic [2:0] os;
      os = os_sel;
      if ($urandom_range(0, 299) == 0) os = 3'($urandom_range(0, 7));
      step(os, DW'($urandom()));
      if ($urandom_range(0, 999) == 0) begin
        reset_n = 1'b0;
        step(os, DW'($urandom()));
        reset_n = 1'b1;
      end
    end

    step(os_sel, data_in);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
